// File: rtl/facto_pkg.sv
// Shared register map for the factorial core register bank.
package facto_pkg;

  localparam int NUM_REGS     = 7;

  localparam int IDX_START    = 0;
  localparam int IDX_CLEAR    = 1;
  localparam int IDX_DONE     = 2;
  localparam int IDX_INTREN   = 3;
  localparam int IDX_OPERAND  = 4;
  localparam int IDX_RESULT_H = 5;
  localparam int IDX_RESULT_L = 6;

  // Bit of s_din that triggers START/CLEAR and clears DONE on write.
  localparam int W1C_BIT      = 0;

endpackage

// File: rtl/facto_addr_dec.sv
// Register index decoder: one-hot write enable and read select.
// An index outside the register map yields all zeros on both outputs.
module facto_addr_dec
  import facto_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic                s_sel,
  input  logic                s_wr,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] rd_sel
);

  // Match the index against every implemented register.
  always_comb begin
    wr_en  = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        wr_en[i]  = s_sel & s_wr;
        rd_sel[i] = s_sel & ~s_wr;
      end
    end
  end

endmodule

// File: rtl/facto_reg_slave.sv
// Bus-slave register bank for the factorial core: storage, read-back,
// start/clear pulses, busy tracking, sticky DONE and a level interrupt.
module facto_reg_slave
  import facto_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int STRIDE_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_sel,
  input  logic                s_wr,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_din,
  output logic [DATA_W-1:0]   s_dout,
  output logic                op_start,
  output logic                op_clear,
  output logic [DATA_W-1:0]   operand,
  input  logic                core_done,
  input  logic [2*DATA_W-1:0] core_result,
  output logic                busy,
  output logic                irq
);

  logic [ADDR_W-1:0]   idx;
  logic [NUM_REGS-1:0] wr_en;
  logic [NUM_REGS-1:0] rd_sel;
  logic                done_r;
  logic                intren_r;
  logic [DATA_W-1:0]   result_h;
  logic [DATA_W-1:0]   result_l;
  logic                start_req;
  logic                clear_req;
  logic                w1c_req;
  logic                done_evt;
  logic [DATA_W-1:0]   rd_data;

  assign idx = s_addr >> STRIDE_LOG2;

  facto_addr_dec #(
    .IDX_W (ADDR_W)
  ) u_addr_dec (
    .s_sel  (s_sel),
    .s_wr   (s_wr),
    .idx    (idx),
    .wr_en  (wr_en),
    .rd_sel (rd_sel)
  );

  // START and core_done are mutually exclusive through busy, so the
  // only real priority questions are CLEAR over everything and set over W1C.
  assign start_req = wr_en[IDX_START] & s_din[W1C_BIT] & ~busy;
  assign clear_req = wr_en[IDX_CLEAR] & s_din[W1C_BIT];
  assign w1c_req   = wr_en[IDX_DONE]  & s_din[W1C_BIT];
  assign done_evt  = core_done & busy;

  // Read mux; write-only and unmapped indices fall through to zero.
  always_comb begin
    rd_data = '0;
    if (rd_sel[IDX_DONE])     rd_data = {{(DATA_W-1){1'b0}}, done_r};
    if (rd_sel[IDX_INTREN])   rd_data = {{(DATA_W-1){1'b0}}, intren_r};
    if (rd_sel[IDX_OPERAND])  rd_data = operand;
    if (rd_sel[IDX_RESULT_H]) rd_data = result_h;
    if (rd_sel[IDX_RESULT_L]) rd_data = result_l;
  end

  // Command pulses, busy/DONE tracking and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_start <= 1'b0;
      op_clear <= 1'b0;
      busy     <= 1'b0;
      done_r   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      op_start <= start_req;
      op_clear <= clear_req;
      irq      <= done_r & intren_r;
      if (clear_req)      busy <= 1'b0;
      else if (start_req) busy <= 1'b1;
      else if (done_evt)  busy <= 1'b0;
      if (clear_req)      done_r <= 1'b0;
      else if (done_evt)  done_r <= 1'b1;
      else if (start_req) done_r <= 1'b0;
      else if (w1c_req)   done_r <= 1'b0;
    end
  end

  // Configuration and result storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand  <= '0;
      intren_r <= 1'b0;
      result_h <= '0;
      result_l <= '0;
    end else begin
      if (wr_en[IDX_OPERAND] && !busy) operand <= s_din;
      if (wr_en[IDX_INTREN]) intren_r <= s_din[0];
      if (clear_req) begin
        result_h <= '0;
        result_l <= '0;
      end else if (done_evt) begin
        result_h <= core_result[2*DATA_W-1:DATA_W];
        result_l <= core_result[DATA_W-1:0];
      end
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_dout <= '0;
    else if (s_sel && !s_wr) s_dout <= rd_data;
  end

endmodule

// File: tb/tb_facto_reg_slave.sv
module tb_facto_reg_slave;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [7:0] A_START  = 8'h00;
  localparam logic [7:0] A_CLEAR  = 8'h08;
  localparam logic [7:0] A_DONE   = 8'h10;
  localparam logic [7:0] A_INTREN = 8'h18;
  localparam logic [7:0] A_OPER   = 8'h20;
  localparam logic [7:0] A_RES_H  = 8'h28;
  localparam logic [7:0] A_RES_L  = 8'h30;
  localparam logic [7:0] A_BAD    = 8'h38;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                s_sel = 1'b0;
  logic                s_wr = 1'b0;
  logic [ADDR_W-1:0]   s_addr = '0;
  logic [DATA_W-1:0]   s_din = '0;
  logic [DATA_W-1:0]   s_dout;
  logic                op_start;
  logic                op_clear;
  logic [DATA_W-1:0]   operand;
  logic                core_done = 1'b0;
  logic [2*DATA_W-1:0] core_result = '0;
  logic                busy;
  logic                irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  facto_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRIDE_LOG2(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_sel       (s_sel),
    .s_wr        (s_wr),
    .s_addr      (s_addr),
    .s_din       (s_din),
    .s_dout      (s_dout),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .operand     (operand),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    tick();
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    logic [31:0] x;
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    exp_q.push_back(e);
    tick();
    s_sel = 1'b0;
    x = exp_q.pop_front();
    n_tests++;
    if (s_dout !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, s_dout, x);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] e);
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, e);
    end
  endtask

  task automatic test_reset();
    #22;
    chk("rst_outputs", {s_dout, op_start, op_clear, busy, irq}, '0);
    chk("rst_operand", operand, 0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) rd(8'(i << 3), 32'h0, "rst_read");
    rd(8'hF8, 32'h0, "rst_read_hi_idx");
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic test_basic();
    wr(A_OPER, 32'h5);
    chk("operand_wr", operand, 5);
    wr(A_INTREN, 32'h1);
    wr(A_START, 32'h1);
    chk("start_pulse", op_start, 1);
    chk("start_busy", busy, 1);
    tick();
    chk("start_pulse_end", op_start, 0);
    core_result = 64'h78; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("done_busy_clr", busy, 0);
    chk("irq_delay", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    rd(A_RES_L, 32'h78, "res_l");
    rd(A_RES_H, 32'h0, "res_h");
    rd(A_DONE, 32'h1, "done_set");
    rd(A_INTREN, 32'h1, "intren_rd");
  endtask

  task automatic test_busy_ignore();
    wr(A_START, 32'h1);
    chk("restart_pulse", op_start, 1);
    wr(A_OPER, 32'h9);
    wr(A_START, 32'h1);
    chk("busy_no_start", op_start, 0);
    chk("busy_operand", operand, 5);
    rd(A_DONE, 32'h0, "start_clr_done");
    rd(A_OPER, 32'h5, "busy_operand_rd");
  endtask

  task automatic test_clear_vs_done();
    core_result = 64'h0000_0011_0000_0022; core_done = 1'b1;
    wr(A_CLEAR, 32'h1);
    core_done = 1'b0;
    chk("clr_pulse", op_clear, 1);
    chk("clr_busy", busy, 0);
    rd(A_DONE, 32'h0, "clr_done");
    chk("clr_pulse_end", op_clear, 0);
    rd(A_RES_L, 32'h0, "clr_res_l");
    rd(A_RES_H, 32'h0, "clr_res_h");
    rd(A_OPER, 32'h5, "clr_keeps_operand");
  endtask

  task automatic test_w1c_vs_done();
    wr(A_START, 32'h1);
    core_result = 64'h0000_0001_0000_0002; core_done = 1'b1;
    wr(A_DONE, 32'h1);
    core_done = 1'b0;
    rd(A_DONE, 32'h1, "w1c_vs_set");
    chk("w1c_irq_on", irq, 1);
    wr(A_DONE, 32'h1);
    chk("w1c_irq_lag", irq, 1);
    tick();
    chk("w1c_irq_off", irq, 0);
    rd(A_DONE, 32'h0, "w1c_done");
    rd(A_RES_H, 32'h1, "w1c_res_h");
  endtask

  task automatic test_invalid();
    wr(A_BAD, 32'hFFFF_FFFF);
    wr(A_RES_H, 32'hFFFF_FFFF);
    wr(A_RES_L, 32'hFFFF_FFFF);
    chk("inv_operand", operand, 5);
    rd(A_BAD, 32'h0, "inv_read");
    rd(A_RES_H, 32'h1, "ro_res_h");
    rd(A_RES_L, 32'h2, "ro_res_l");
    rd(A_INTREN, 32'h1, "inv_intren");
    wr(A_DONE, 32'h0);
    rd(A_START, 32'h0, "wo_start_rd");
  endtask

  task automatic test_back_to_back();
    logic        is_w [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
    logic [7:0]  ad   [8] = '{A_OPER, A_OPER, A_RES_H, A_RES_L, A_CLEAR, A_INTREN, A_INTREN, A_OPER};
    logic [31:0] dv   [8] = '{32'hA5, 32'hA5, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 32'hA5};
    logic [31:0] x;
    for (int i = 0; i < 8; i++) begin
      s_sel = 1'b1; s_wr = is_w[i]; s_addr = ad[i]; s_din = dv[i];
      if (!is_w[i]) exp_q.push_back(dv[i]);
      tick();
      if (!is_w[i]) begin
        x = exp_q.pop_front();
        n_tests++;
        if (s_dout !== x) begin
          n_fail++;
          $display("FAIL b2b_read[%0d]: got %h expected %h", i, s_dout, x);
        end
      end
    end
    s_sel = 1'b0; s_wr = 1'b0;
    tick();
    chk("dout_hold", s_dout, 32'hA5);
  endtask

  task automatic test_reset_mid();
    wr(A_START, 32'h1);
    chk("mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {s_dout, op_start, op_clear, busy, irq}, '0);
    chk("mid_rst_operand", operand, 0);
    #3 reset_n = 1'b1;
    tick();
    chk("mid_no_pulse", {op_start, op_clear}, 0);
    tick();
    chk("mid_no_pulse2", {op_start, op_clear}, 0);
    rd(A_INTREN, 32'h0, "mid_intren");
    rd(A_RES_H, 32'h0, "mid_res_h");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_clear_vs_done();
    test_w1c_vs_done();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/facto_reg_slave.md
# facto_reg_slave

Parametrised bus-slave register bank for the factorial core. It replaces the one-hot enable decoder with a complete register block: decode, write storage, registered read-back, start/clear pulse generation, busy tracking, sticky DONE status, and a level interrupt. It sits between the system bus slave port and the factorial datapath.

## Interface
- ADDR_W, 8, bus address width
- DATA_W, 32, bus data, operand and result-half width
- STRIDE_LOG2, 3, log2 of address bytes per register; register index = s_addr >> STRIDE_LOG2
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_sel  in  1  slave select; an access occurs only when 1
- s_wr  in  1  1 = write, 0 = read (qualified by s_sel)
- s_addr  in  ADDR_W  byte address
- s_din  in  DATA_W  write data
- s_dout  out  DATA_W  registered read data
- op_start  out  1  one-cycle start pulse to the core
- op_clear  out  1  one-cycle clear pulse to the core
- operand  out  DATA_W  operand register contents
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  2*DATA_W  result, valid while core_done=1
- busy  out  1  computation in flight
- irq  out  1  interrupt, level

## Operation
- Register indices: 0 START (W), 1 CLEAR (W), 2 DONE (R, W1C), 3 INTREN (RW bit0), 4 OPERAND (RW), 5 RESULT_H (RO), 6 RESULT_L (RO). Any other index is a no-op: writes are ignored and reads return 0.
- START write with s_din[0]=1 while busy=0: op_start=1 for one cycle, busy set, DONE cleared. Ignored while busy=1.
- CLEAR write with s_din[0]=1: op_clear=1 for one cycle; clears busy, DONE, RESULT_H and RESULT_L. OPERAND and INTREN are kept.
- core_done=1 while busy=1: RESULT_H/L capture core_result[2*DATA_W-1:DATA_W] and [DATA_W-1:0]; DONE set; busy cleared. core_done while busy=0 is ignored.
- DONE write with s_din[0]=1 clears DONE.
- OPERAND writes are ignored while busy=1.
- Read-only and write-only registers: writes to RESULT_* have no effect; reads of START and CLEAR return 0.
- irq = DONE & INTREN, registered.
- Read data is zero-extended. DONE and INTREN return their value in bit0.

Simultaneous events, same cycle:
- CLEAR write and core_done: CLEAR wins; no capture, DONE=0.
- DONE W1C write and core_done: set wins; DONE=1.
- START write and core_done: cannot occur with an effect, because START is ignored while busy.

## Timing
- Reset values: s_dout=0, op_start=0, op_clear=0, operand=0, busy=0, irq=0; DONE=0, INTREN=0, RESULT_H=RESULT_L=0.
- Writes take effect at the sampling edge. op_start and op_clear are asserted in the cycle after that edge, for exactly one cycle.
- Read latency is 1: s_dout is updated at the edge sampling s_sel=1, s_wr=0. It holds its value when there is no read.
- A read of DONE in the same cycle as core_done returns the old value.
- irq follows DONE/INTREN with one cycle of delay.
- reset_n low mid-operation returns everything to the reset values immediately. No pulse is emitted on deassertion.
- Back-to-back accesses are supported every cycle; there are no wait states.

## Structure
- Package facto_pkg holds the register index localparams (IDX_START..IDX_RESULT_L) and the W1C bit position.
- Sub-module facto_addr_dec: combinational. Inputs are s_sel, s_wr and the index. Outputs are a one-hot write enable and a read select, with an invalid index giving all zeros.
- All storage and the busy/DONE logic live in the top module.

## Test plan
- Reset, then read every index 0..7 -> s_dout=0 one cycle after each read; irq=0, busy=0.
- Write OPERAND 0x5, write INTREN 1, write START 1; core_done with result 0x0000_0000_0000_0078 -> op_start pulses 1 cycle; busy 1→0; read RESULT_L=0x78, RESULT_H=0, DONE=1; irq=1 one cycle after DONE.
- While busy: write OPERAND 0x9 and write START 1 -> OPERAND still 0x5; no op_start pulse.
- Same cycle: CLEAR write and core_done -> DONE=0, RESULT_L=0, op_clear pulses, busy=0.
- DONE=1, then W1C write to DONE in the same cycle as core_done -> DONE stays 1. W1C alone -> DONE=0, irq falls one cycle later.
- Write 0xFFFF_FFFF to address 0x38 and to RESULT_H -> no register change, and reads return 0 / the previous result respectively. Assert reset_n mid-computation -> all outputs 0 at once.
